rvfi_trace_fifo: RTL
====================

// Module: rvfi_trace_fifo
// PURPOSE
// Downstream consumer of dtcore32's RVFI retire port. It captures each retired-instruction packet
// (rvfi_valid=1) into a DEPTH-entry FIFO, then serialises it as six 32-bit words on a valid/ready
// trace stream for a debug UART/JTAG drain. Overflow is lossy: when full, packets are dropped and counted.
// PARAMETERS
// DEPTH   8   packet entries; power of 2, >=2
// DROP_W  16  width of saturating drop counter
// PORTS
// clk_i          in   1   clock, rising edge
// rst_ni         in   1   reset, asynchronous, active-low
// rvfi_valid     in   1   retire strobe from core
// rvfi_order     in   64  retire order; low 32 bits captured
// rvfi_insn      in   32  instruction word
// rvfi_trap/halt/intr in 1 each  retire flags
// rvfi_mode      in   2   privilege mode
// rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr  in  5 each  register indices
// rvfi_rd_wdata, rvfi_pc_rdata, rvfi_pc_wdata  in 32 each
// enable_i       in   1   capture enable; 0 = ignore retires (not counted)
// clear_i        in   1   synchronous flush
// trace_data_o   out  32  current stream word
// trace_valid_o  out  1   word valid
// trace_ready_i  in   1   sink ready; transfer when valid&&ready
// trace_last_o   out  1   high on word 5 of a packet
// fifo_level_o   out  $clog2(DEPTH)+1  packets stored (incl. one in transmission)
// drop_count_o   out  DROP_W  packets dropped while full, saturating
// overflow_o     out  1   sticky: set on first drop
// BEHAVIOUR
// Reset (rst_ni=0, async): FIFO empty, FSM=IDLE, all outputs 0 (trace_data_o=0, level=0, drops=0).
// Packet word order: W0=order[31:0], W1=pc_rdata, W2=insn, W3=pc_wdata, W4=rd_wdata,
//   W5={trap,halt,intr,mode[1:0],12'b0,rs2_addr,rs1_addr,rd_addr}.
// Push: on rising edge with rvfi_valid&&enable_i&&!clear_i; if accepted, the entry is stored at wr_ptr and level+1.
// Accept if level<DEPTH, OR level==DEPTH and the head packet's W5 transfers the same cycle (pop+push).
// Else drop: drop_count+1 (hold at all-ones), overflow_o<=1; FIFO unchanged.
// FSM IDLE: trace_valid_o=0; if level>0 -> SEND with idx=0 next cycle.
// FSM SEND: trace_valid_o=1, trace_data_o=W[idx] of head entry (mux from storage, stable while stalled).
// On handshake idx<5 -> idx+1; idx==5 -> pop head (level-1), idx=0, stay SEND if level after pop >0
//   (back-to-back packets, no bubble) else IDLE.
// Without ready: word and valid held unchanged indefinitely (AXI-stream rule; valid never withdrawn).
// Latency: packet pushed at edge N -> W0 valid in cycle after edge N+1 when FIFO was empty (1-cycle IDLE->SEND).
// Pointers wrap modulo DEPTH; full/empty are derived from level, not pointer compare.
// clear_i=1: next edge empties FIFO, idx=0, FSM=IDLE, drop_count=0, overflow=0; aborts a packet mid-stream
//   (trace_valid_o low next cycle, partial packet is not resumed). clear_i has priority over simultaneous push.
// enable_i low: new retires are ignored; drain continues normally.
// Reset mid-packet: async clear of all state; sink sees trace_valid_o fall immediately.
// TESTING
// T1 single retire order=5,pc=0x100,insn=0x00500093,rd=1,wdata=5, ready=1 -> 6 words 5,0x100,0x00500093,0x104,5,0x00000001, last on 6th.
// T2 DEPTH=8, 10 retires with ready=0 -> level=8, drop_count=2, overflow=1; release ready -> first 8 orders in sequence.
// T3 level=8, W5 handshake and rvfi_valid same cycle -> packet accepted, level stays 8, no drop.
// T4 ready toggling 1/0 every cycle over 3 packets -> no word duplicated or skipped, no valid gap between packets.
// T5 clear_i after W2 of packet with 3 queued -> valid=0 next cycle, level=0, drops=0; next retire starts at W0.
// T6 rst_ni pulsed low mid-SEND asynchronously -> all outputs 0 before next clock edge; enable_i=0 retires -> level, drops stay 0.

Source files
------------

// File: rtl/rvfi_trace_fifo.sv
// Retire-packet trace FIFO: stores RVFI retire packets and streams each one
// as six 32-bit words over a valid/ready interface. Packets that arrive while full are dropped and counted.
module rvfi_trace_fifo #(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       rvfi_valid,
  input  logic [63:0]                rvfi_order,
  input  logic [31:0]                rvfi_insn,
  input  logic                       rvfi_trap,
  input  logic                       rvfi_halt,
  input  logic                       rvfi_intr,
  input  logic [1:0]                 rvfi_mode,
  input  logic [4:0]                 rvfi_rs1_addr,
  input  logic [4:0]                 rvfi_rs2_addr,
  input  logic [4:0]                 rvfi_rd_addr,
  input  logic [31:0]                rvfi_rd_wdata,
  input  logic [31:0]                rvfi_pc_rdata,
  input  logic [31:0]                rvfi_pc_wdata,
  input  logic                       enable_i,
  input  logic                       clear_i,
  output logic [31:0]                trace_data_o,
  output logic                       trace_valid_o,
  input  logic                       trace_ready_i,
  output logic                       trace_last_o,
  output logic [$clog2(DEPTH):0]     fifo_level_o,
  output logic [DROP_W-1:0]          drop_count_o,
  output logic                       overflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

  state_e            state_q;
  logic [2:0]        idx_q;
  logic [LW-1:0]     level_q, level_d;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [DROP_W-1:0] drop_q;
  logic              ovf_q;
  logic [5:0][31:0]  mem_q [DEPTH];
  logic [5:0][31:0]  pkt_d;
  logic [31:0]       data_d;
  logic              hs_d, pop_d, push_req_d, accept_d, drop_d;

  assign pkt_d = {{rvfi_trap, rvfi_halt, rvfi_intr, rvfi_mode, 12'b0,
                   rvfi_rs2_addr, rvfi_rs1_addr, rvfi_rd_addr},
                  rvfi_rd_wdata, rvfi_pc_wdata, rvfi_insn, rvfi_pc_rdata,
                  rvfi_order[31:0]};

  assign hs_d       = (state_q == SEND) && trace_ready_i;
  assign pop_d      = hs_d && (idx_q == 3'd5);
  assign push_req_d = rvfi_valid && enable_i && !clear_i;
  // A full FIFO still accepts when the head's last word leaves this same cycle.
  assign accept_d   = push_req_d && ((level_q < LW'(DEPTH)) || pop_d);
  assign drop_d     = push_req_d && !accept_d;
  assign level_d    = level_q + {{PW{1'b0}}, accept_d} - {{PW{1'b0}}, pop_d};

  always_ff @(posedge clk_i) begin
    if (accept_d) begin
      mem_q[wr_ptr_q] <= pkt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      idx_q    <= 3'd0;
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
    end else if (clear_i) begin
      state_q  <= IDLE;
      idx_q    <= 3'd0;
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      level_q <= level_d;
      if (accept_d) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_d)    rd_ptr_q <= rd_ptr_q + PW'(1);
      if (drop_d) begin
        ovf_q <= 1'b1;
        if (drop_q != {DROP_W{1'b1}}) drop_q <= drop_q + DROP_W'(1);
      end
      case (state_q)
        IDLE: begin
          if (level_q != '0) begin
            state_q <= SEND;
            idx_q   <= 3'd0;
          end
        end
        SEND: begin
          if (hs_d) begin
            if (idx_q == 3'd5) begin
              idx_q   <= 3'd0;
              state_q <= (level_d != '0) ? SEND : IDLE;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          idx_q   <= 3'd0;
        end
      endcase
    end
  end

  always_comb begin
    data_d = 32'd0;
    if (state_q == SEND) begin
      case (idx_q)
        3'd0:    data_d = mem_q[rd_ptr_q][0];
        3'd1:    data_d = mem_q[rd_ptr_q][1];
        3'd2:    data_d = mem_q[rd_ptr_q][2];
        3'd3:    data_d = mem_q[rd_ptr_q][3];
        3'd4:    data_d = mem_q[rd_ptr_q][4];
        3'd5:    data_d = mem_q[rd_ptr_q][5];
        default: data_d = 32'd0;
      endcase
    end else begin
      data_d = 32'd0;
    end
  end

  assign trace_data_o  = data_d;
  assign trace_valid_o = (state_q == SEND);
  assign trace_last_o  = (state_q == SEND) && (idx_q == 3'd5);
  assign fifo_level_o  = level_q;
  assign drop_count_o  = drop_q;
  assign overflow_o    = ovf_q;

endmodule
